timer_loader: RTL and testbench
===============================

Name: timer_loader

Overview:
- Upstream feeder for the 5-bit countdown timer: drives the timer's `value`/`valid` load inputs and watches its `trigger` output.
- Holds a small FIFO of reload values written by the control side.
- Issues the next queued value each time the timer fires, so a sequence of intervals runs back-to-back without software intervention.
- Also counts completed intervals and flags illegal zero-length requests.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- AW, 2, FIFO pointer width (log2 DEPTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  control side offers a reload value
- wr_data  input  5  reload value (timer ticks)
- wr_ready  output  1  FIFO can accept; equals ~full
- run_en  input  1  permits new loads from IDLE
- flush  input  1  discard queue, abort sequencing
- timer_trigger  input  1  trigger output of the timer
- value  output  5  load value to timer
- valid  output  1  one-cycle load strobe to timer
- level  output  AW+1  current FIFO occupancy
- busy  output  1  state != IDLE
- done_cnt  output  8  intervals completed, saturating
- zero_err  output  1  sticky: a zero write was dropped

Behaviour:
- Reset values:
  - value=0, valid=0, level=0, busy=0, done_cnt=0, zero_err=0, state=IDLE.
  - FIFO pointers cleared.
  - reset has priority over every other input.
- Write handshake:
  - A write is accepted at an edge when wr_valid & wr_ready.
  - wr_ready is computed from registered occupancy. A pop in the same cycle does not open a slot for a push while full.
- Zero writes:
  - An accepted write with wr_data==0 is not stored; level is unchanged and zero_err sets to 1.
  - zero_err clears only on reset.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: if run_en & level!=0, at the next edge:
    - value<=head, valid<=1, pop head, go to LOAD.
    - Otherwise stay; valid=0.
  - LOAD: valid is high for exactly this one cycle, so the timer loads at the end of it.
    - Unconditionally go to RUN; valid<=0.
    - timer_trigger is ignored in LOAD, since it may be stale from the prior interval.
  - RUN: wait for timer_trigger==1. On that edge:
    - done_cnt increments, saturating at 255.
    - If level!=0: value<=head, valid<=1, pop, go to LOAD. run_en is not checked here, so a running sequence drains the queue.
    - Else go to IDLE.
- Latency:
  - Push into an empty FIFO in IDLE with run_en=1, accepted at edge k → valid high in the cycle after edge k+1.
  - Trigger seen at edge t with data queued → valid high in the cycle after edge t.
- Simultaneous push and pop: level is unchanged and the data paths stay independent. Pushing into an empty FIFO never bypasses to value the same cycle.
- flush:
  - At the edge, clears pointers/level, forces IDLE, valid<=0. value holds its last value.
  - done_cnt and zero_err are unaffected.
  - A write coinciding with flush is discarded.
  - flush during LOAD cancels the pending strobe. It does not retract an already-registered load, which the timer has taken.
- Wrap-around: pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- busy=1 in LOAD and RUN.
- value holds its last loaded value when valid=0.

Test Plan:
- Reset, then push 5, 3 with run_en=1 → valid pulses once with value=5, 2 cycles after first push accepted. Model trigger after 5 ticks → valid pulse with value=3. Next trigger → IDLE, done_cnt=2, busy=0.
- Push DEPTH=4 values (1,2,3,4) with run_en=0 → level=4, wr_ready=0. 5th write ignored. Raise run_en → loads 1,2,3,4 in order, each one cycle after its preceding trigger.
- Write 0 then 7 → zero_err=1, level=1, first load value=7. zero_err stays 1 after done.
- Hold timer_trigger=1 continuously with queue 2,2 → trigger ignored in each LOAD cycle. Loads are spaced exactly 2 cycles apart (LOAD, RUN).
- Mid-RUN with 2 entries queued, assert flush plus a write → level=0, state IDLE, valid never asserts, later trigger does not increment done_cnt.
- Drive 256 one-tick intervals → done_cnt saturates at 255. Reset mid-RUN → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/timer_loader.sv
// Reload-value FIFO that feeds a countdown timer, issuing the next queued
// interval each time the timer fires, plus interval counting and zero-write flagging.
module timer_loader #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [4:0]    wr_data,
  output logic          wr_ready,
  input  logic          run_en,
  input  logic          flush,
  input  logic          timer_trigger,
  output logic [4:0]    value,
  output logic          valid,
  output logic [AW:0]   level,
  output logic          busy,
  output logic [7:0]    done_cnt,
  output logic          zero_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [4:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic [AW:0]   level_q, level_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    done_q, done_d;
  logic          zerr_q, zerr_d;
  logic [4:0]    mem_q [DEPTH];

  logic wr_acc;
  logic push;
  logic pop;

  assign wr_ready = (level_q != FULL_LVL);
  assign wr_acc   = wr_valid & wr_ready;
  assign push     = wr_acc & (wr_data != '0) & ~flush;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    done_d   = done_q;
    zerr_d   = zerr_q;
    pop      = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (wr_acc && (wr_data == '0)) zerr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (run_en && (level_q != '0)) begin
          pop     = 1'b1;
          value_d = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (timer_trigger) begin
          if (done_q != 8'hFF) done_d = done_q + 8'd1;
          if (level_q != '0) begin
            pop     = 1'b1;
            value_d = mem_q[rd_ptr_q];
            valid_d = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // flush overrides any load decided above but leaves done_cnt/zero_err alone
    if (flush) begin
      state_d  = IDLE;
      value_d  = value_q;
      valid_d  = 1'b0;
      pop      = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      valid_q  <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= '0;
      zerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
      zerr_q   <= zerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign level    = level_q;
  assign busy     = (state_q != IDLE);
  assign done_cnt = done_q;
  assign zero_err = zerr_q;

endmodule

// File: tb/tb_timer_loader.sv
// Bench for timer_loader: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the loader and a simple timer model.
module tb_timer_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [4:0]    wr_data;
  logic          wr_ready;
  logic          run_en;
  logic          flush;
  logic          timer_trigger;
  logic [4:0]    value;
  logic          valid;
  logic [AW:0]   level;
  logic          busy;
  logic [7:0]    done_cnt;
  logic          zero_err;

  int checks = 0;
  int errors = 0;

  timer_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .run_en(run_en), .flush(flush),
    .timer_trigger(timer_trigger), .value(value), .valid(valid),
    .level(level), .busy(busy), .done_cnt(done_cnt), .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  // Timer model: loads on valid, fires for one cycle when one tick remains.
  logic       tmode;
  logic       trig_drv;
  logic [4:0] tcnt;
  always @(posedge clk) begin
    if (reset) tcnt <= '0;
    else if (valid) tcnt <= value;
    else if (tcnt != 0) tcnt <= tcnt - 5'd1;
  end
  assign timer_trigger = tmode ? (tcnt == 5'd1) : trig_drv;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending values, a strobe flag and a waiting flag.
  int   mq[$];
  bit   m_ok = 0;
  bit   m_strobe, m_wait, m_zerr;
  int   m_value, m_done;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); m_strobe = 0; m_wait = 0; m_zerr = 0;
      m_value = 0; m_done = 0; m_ok = 1;
    end else if (m_ok) begin
      bit acc;
      bit give;
      acc  = wr_valid && (mq.size() < DEPTH);
      give = 0;
      if (acc && wr_data == 0) m_zerr = 1;
      if (m_wait && timer_trigger && m_done < 255) m_done++;
      if (flush) begin
        mq.delete(); m_strobe = 0; m_wait = 0;
      end else begin
        if (m_strobe) begin
          m_strobe = 0; m_wait = 1;
        end else if (m_wait) begin
          if (timer_trigger) begin
            m_wait = 0;
            give = (mq.size() != 0);
          end
        end else begin
          give = run_en && (mq.size() != 0);
        end
        if (give) begin
          m_value = mq.pop_front();
          m_strobe = 1;
        end
        if (acc && wr_data != 0) mq.push_back(int'(wr_data));
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && !reset) begin
      chk("value", int'(value), m_value);
      chk("valid", int'(valid), int'(m_strobe));
      chk("level", int'(level), mq.size());
      chk("busy", int'(busy), int'(m_strobe | m_wait));
      chk("done_cnt", int'(done_cnt), m_done);
      chk("zero_err", int'(zero_err), int'(m_zerr));
      chk("wr_ready", int'(wr_ready), int'(mq.size() < DEPTH));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; wr_valid = 0; wr_data = 0; flush = 0; run_en = 0;
    trig_drv = 0; tmode = 0;
    step();
    reset = 0;
  endtask

  task automatic push(input int d);
    wr_valid = 1; wr_data = 5'(d);
    step();
    wr_valid = 0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done_cnt == 8'(n) && !busy) break;
      step();
    end
    chk(name, int'(done_cnt == 8'(n) && !busy), 1);
  endtask

  initial begin
    int vcyc[$];
    reset = 1; wr_valid = 0; wr_data = 0; run_en = 0; flush = 0;
    trig_drv = 0; tmode = 0;

    // Reset state
    do_reset();
    chk("rst_valid", int'(valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_cnt), 0);

    // 5 then 3, back-to-back via the timer model
    run_en = 1; tmode = 1;
    wr_valid = 1; wr_data = 5'd5; step();
    chk("t1_no_bypass", int'(valid), 0);
    wr_data = 5'd3; step();
    wr_valid = 0;
    chk("t1_first_valid", int'(valid), 1);
    chk("t1_first_value", int'(value), 5);
    wait_done("t1_done2", 2, 100);
    chk("t1_done_val", int'(done_cnt), 2);

    // Fill to DEPTH with run_en low, 5th write refused
    do_reset(); tmode = 1;
    push(1); push(2); push(3); push(4);
    chk("t2_level4", int'(level), 4);
    chk("t2_ready0", int'(wr_ready), 0);
    push(9);
    chk("t2_level_still4", int'(level), 4);
    run_en = 1; step();
    chk("t2_first_value", int'(value), 1);
    chk("t2_first_valid", int'(valid), 1);
    wait_done("t2_done4", 4, 200);

    // Zero write dropped and flagged
    do_reset(); tmode = 1;
    push(0); push(7);
    chk("t3_zerr", int'(zero_err), 1);
    chk("t3_level1", int'(level), 1);
    run_en = 1; step();
    chk("t3_value7", int'(value), 7);
    wait_done("t3_done1", 1, 100);
    chk("t3_zerr_sticky", int'(zero_err), 1);

    // Trigger held high: loads exactly two cycles apart
    do_reset(); trig_drv = 1;
    push(2); push(2);
    run_en = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (valid) vcyc.push_back(i);
    end
    chk("t4_loads", vcyc.size(), 2);
    if (vcyc.size() == 2) chk("t4_spacing", vcyc[1] - vcyc[0], 2);
    chk("t4_done2", int'(done_cnt), 2);

    // Flush mid-RUN with a coinciding write
    do_reset(); run_en = 1;
    push(9); step(); step();
    push(4); push(6);
    chk("t5_level2", int'(level), 2);
    chk("t5_busy", int'(busy), 1);
    flush = 1; wr_valid = 1; wr_data = 5'd5; step();
    flush = 0; wr_valid = 0;
    chk("t5_level0", int'(level), 0);
    chk("t5_idle", int'(busy), 0);
    chk("t5_novalid", int'(valid), 0);
    trig_drv = 1; step(); step(); trig_drv = 0;
    chk("t5_done0", int'(done_cnt), 0);
    chk("t5_value_held", int'(value), 9);

    // Saturation of done_cnt, then reset mid-run
    do_reset(); run_en = 1; trig_drv = 1;
    wr_valid = 1; wr_data = 5'd1;
    repeat (600) step();
    chk("t6_sat", int'(done_cnt), 255);
    chk("t6_busy", int'(busy), 1);
    reset = 1; step(); reset = 0; wr_valid = 0; trig_drv = 0;
    chk("t6_rst_value", int'(value), 0);
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done_cnt), 0);
    chk("t6_rst_zerr", int'(zero_err), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) tmode = $urandom_range(0, 1);
      reset    = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      wr_valid = $urandom_range(0, 1);
      wr_data  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      run_en   = ($urandom_range(0, 3) != 0);
      trig_drv = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 0; flush = 0; wr_valid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
